// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared std_mem definitions used by the request/response interface, the
// responder and its response buffer:
//   - default field widths of the std_mem_intf bus
//   - RESP_SLOTS: number of response slots the responder may reserve
//   - mem_resp_t: one buffered response (read_enable, write_enable, addr,
//     data, id)
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_MASK_WIDTH = MEM_DATA_WIDTH / 8;
    localparam int MEM_ID_WIDTH   = 4;

    localparam int RESP_SLOTS = 2;

    typedef struct packed {
        logic                      read_enable;
        logic [MEM_MASK_WIDTH-1:0] write_enable;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
        logic [MEM_ID_WIDTH-1:0]   id;
    } mem_resp_t;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// std_mem_intf
// Valid/ready memory request/response channel. A transfer happens on a rising
// edge where valid && ready; the sender holds valid and payload until then.
// Signals: valid, ready, read_enable, write_enable (byte mask), addr, data, id.
// Modports:
//   master / out : drives valid + payload, samples ready
//   slave  / in  : samples valid + payload, drives ready
// -----------------------------------------------------------------------------
interface std_mem_intf #(
    parameter int ADDR_WIDTH = mem_responder_pkg::MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_responder_pkg::MEM_DATA_WIDTH,
    parameter int MASK_WIDTH = mem_responder_pkg::MEM_MASK_WIDTH,
    parameter int ID_WIDTH   = mem_responder_pkg::MEM_ID_WIDTH
) ();

    logic                  valid;
    logic                  ready;
    logic                  read_enable;
    logic [MASK_WIDTH-1:0] write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;

    modport master (output valid, read_enable, write_enable, addr, data, id, input ready);
    modport slave  (input valid, read_enable, write_enable, addr, data, id, output ready);
    modport out    (output valid, read_enable, write_enable, addr, data, id, input ready);
    modport in     (input valid, read_enable, write_enable, addr, data, id, output ready);

endinterface

// File: rtl/mem_responder_buffer.sv
// -----------------------------------------------------------------------------
// mem_responder_buffer
// Two-entry in-order response FIFO with fall-through: when empty, an incoming
// response is presented on the output in the same cycle and is only stored if
// the consumer does not take it. The producer guarantees (through its slot
// counter) that the FIFO never overflows, so there is no input ready.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, in_data   response entering the buffer
//   out_valid/out_ready response stream towards the consumer
//   out_data            head response (held stable while stalled)
// -----------------------------------------------------------------------------
module mem_responder_buffer
    import mem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    input  mem_resp_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output mem_resp_t out_data
);

    mem_resp_t  entry_reg [RESP_SLOTS];
    logic [1:0] count_reg;
    logic       head_reg;

    logic empty;
    logic pop;
    logic pop_entry;
    logic push;
    logic tail;

    assign empty     = (count_reg == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : entry_reg[head_reg];
    assign pop       = out_valid && out_ready;
    // An incoming response bypasses storage only if it leaves immediately.
    assign push      = in_valid && !(empty && pop);
    assign pop_entry = pop && !empty;
    assign tail      = head_reg ^ count_reg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
            for (int i = 0; i < RESP_SLOTS; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                entry_reg[tail] <= in_data;
            end
            if (pop_entry) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop_entry};
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Terminates a std_mem_intf request stream in a local word-addressed RAM with
// byte-masked writes and returns in-order responses on mem_out.
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset (RAM contents are kept)
//   mem_in   request stream (std_mem_intf.in)
//   mem_out  response stream (std_mem_intf.out)
// Parameters: DEPTH (power of two, >= 2); INDEX_WIDTH is derived.
// Build option: MEM_RESPONDER_WRITE_ACK_EN - when defined, requests without
// read_enable also produce a response (data 0, write_enable echoed).
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    std_mem_intf.in       mem_in,
    std_mem_intf.out      mem_out
);

    localparam int INDEX_WIDTH = $clog2(DEPTH);

`ifdef MEM_RESPONDER_WRITE_ACK_EN
    localparam bit WRITE_ACK_EN = 1'b1;
`else
    localparam bit WRITE_ACK_EN = 1'b0;
`endif

    // Elaboration-time width and depth checks.
    if ($bits(mem_in.addr) != $bits(mem_out.addr) || $bits(mem_in.data) != $bits(mem_out.data) ||
        $bits(mem_in.write_enable) != $bits(mem_out.write_enable) || $bits(mem_in.id) != $bits(mem_out.id))
    begin : g_port_width_mismatch
        $error("mem_responder: mem_in and mem_out widths differ");
    end
    if ($bits(mem_in.write_enable) != $bits(mem_in.data) / 8) begin : g_mask_width_bad
        $error("mem_responder: MASK_WIDTH must equal DATA_WIDTH/8");
    end
    if ($bits(mem_in.addr) < INDEX_WIDTH) begin : g_addr_too_narrow
        $error("mem_responder: ADDR_WIDTH must be at least INDEX_WIDTH");
    end
    if ($bits(mem_in.addr) != MEM_ADDR_WIDTH || $bits(mem_in.data) != MEM_DATA_WIDTH ||
        $bits(mem_in.id) != MEM_ID_WIDTH) begin : g_pkg_width_mismatch
        $error("mem_responder: interface widths must match mem_resp_t");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_bad
        $error("mem_responder: DEPTH must be a power of two and at least 2");
    end

    logic [MEM_DATA_WIDTH-1:0] ram [DEPTH];

    logic [1:0]             occ_reg;
    logic                   pipe_valid_reg;
    mem_resp_t              pipe_reg;

    logic [INDEX_WIDTH-1:0] idx;
    logic                   accept;
    logic                   gen;
    logic                   resp_fire;
    logic                   out_valid;
    mem_resp_t              out_data;

    assign idx          = mem_in.addr[INDEX_WIDTH-1:0];
    // Ready looks only at the slot counter, so it never depends on mem_out.
    assign mem_in.ready = (occ_reg < 2'(RESP_SLOTS)) && rst;
    assign accept       = mem_in.valid && mem_in.ready;
    assign gen          = accept && (mem_in.read_enable || WRITE_ACK_EN);
    assign resp_fire    = out_valid && mem_out.ready;

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < MEM_MASK_WIDTH; b++) begin
                if (mem_in.write_enable[b]) begin
                    ram[idx][b*8 +: 8] <= mem_in.data[b*8 +: 8];
                end
            end
        end
    end

    // Read stage: the registered read returns the pre-write word, which gives
    // read-first behaviour for combined read+write requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg        <= 2'd0;
            pipe_valid_reg <= 1'b0;
            pipe_reg       <= '0;
        end else begin
            occ_reg        <= occ_reg + {1'b0, gen} - {1'b0, resp_fire};
            pipe_valid_reg <= gen;
            if (gen) begin
                pipe_reg.read_enable  <= mem_in.read_enable;
                pipe_reg.write_enable <= mem_in.read_enable ? '0 : mem_in.write_enable;
                pipe_reg.addr         <= mem_in.addr;
                pipe_reg.id           <= mem_in.id;
                pipe_reg.data         <= mem_in.read_enable ? ram[idx] : '0;
            end
        end
    end

    mem_responder_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_valid_reg),
        .in_data   (pipe_reg),
        .out_valid (out_valid),
        .out_ready (mem_out.ready),
        .out_data  (out_data)
    );

    assign mem_out.valid        = out_valid;
    assign mem_out.read_enable  = out_data.read_enable;
    assign mem_out.write_enable = out_data.write_enable;
    assign mem_out.addr         = out_data.addr;
    assign mem_out.data         = out_data.data;
    assign mem_out.id           = out_data.id;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. A word-array model of the RAM and a
// queue of owed responses predict every response, mem_in.ready and
// mem_out.valid. Honours MEM_RESPONDER_WRITE_ACK_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DEPTH = 256;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    std_mem_intf req_if ();
    std_mem_intf rsp_if ();

    mem_responder #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_in  (req_if),
        .mem_out (rsp_if)
    );

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int accept_cnt = 0;
    int cycle_cnt = 0;
    bit last_in_fire;
    bit stall_prev;
    mem_resp_t stall_payload;
    mem_resp_t exp_q [$];
    logic [MEM_DATA_WIDTH-1:0] model_mem [DEPTH];

    function automatic mem_resp_t get_resp();
        mem_resp_t r;
        r.read_enable  = rsp_if.read_enable;
        r.write_enable = rsp_if.write_enable;
        r.addr         = rsp_if.addr;
        r.data         = rsp_if.data;
        r.id           = rsp_if.id;
        return r;
    endfunction

    // One clock cycle: sample between edges, check, update the model, advance.
    task automatic tick();
        mem_resp_t got;
        mem_resp_t exp;
        bit exp_ready;
        bit out_fire;
        int idx;
        #1;
        got          = get_resp();
        last_in_fire = (req_if.valid === 1'b1) && (req_if.ready === 1'b1);
        out_fire     = (rsp_if.valid === 1'b1) && (rsp_if.ready === 1'b1);
        exp_ready    = (rst === 1'b1) && (exp_q.size() < RESP_SLOTS);
        checks++;
        if (req_if.ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b need %b (owed=%0d)", req_if.ready, exp_ready, exp_q.size());
        end
        checks++;
        if (rsp_if.valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b need %b (owed=%0d)", rsp_if.valid, exp_q.size() != 0, exp_q.size());
        end
        if (stall_prev) begin
            checks++;
            if (got !== stall_payload) begin
                errors++;
                $display("FAIL stall_stable: got %h need %h", got, stall_payload);
            end
        end
        if (out_fire && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            resp_cnt++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL resp: got %h need %h", got, exp);
            end else begin
                $display("resp id=%0d addr=%h re=%0b we=%b data=%h", got.id, got.addr, got.read_enable, got.write_enable, got.data);
            end
        end
        stall_prev    = (rsp_if.valid === 1'b1) && (rsp_if.ready !== 1'b1);
        stall_payload = got;
        if (last_in_fire) begin
            accept_cnt++;
            idx = int'(req_if.addr % DEPTH);
            if (req_if.read_enable || WACK) begin
                exp.read_enable  = req_if.read_enable;
                exp.write_enable = req_if.read_enable ? '0 : req_if.write_enable;
                exp.addr         = req_if.addr;
                exp.id           = req_if.id;
                exp.data         = req_if.read_enable ? model_mem[idx] : '0;
                exp_q.push_back(exp);
            end
            for (int b = 0; b < MEM_MASK_WIDTH; b++) begin
                if (req_if.write_enable[b]) model_mem[idx][b*8 +: 8] = req_if.data[b*8 +: 8];
            end
        end
        @(posedge clk);
        cycle_cnt++;
        @(negedge clk);
    endtask

    task automatic send(input logic re, input logic [MEM_MASK_WIDTH-1:0] we, input logic [MEM_ADDR_WIDTH-1:0] addr,
                        input logic [MEM_DATA_WIDTH-1:0] data, input logic [MEM_ID_WIDTH-1:0] id);
        int n;
        n = 0;
        req_if.valid = 1'b1;
        req_if.read_enable = re;
        req_if.write_enable = we;
        req_if.addr = addr;
        req_if.data = data;
        req_if.id = id;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 50);
        checks++;
        if (!last_in_fire) begin
            errors++;
            $display("FAIL send_accept: not accepted after %0d cycles, need acceptance", n);
        end
        req_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_if.valid = 1'b0;
        rsp_if.ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still owed after %0d cycles, need 0", exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 0", req_if.ready);
        end
        checks++;
        if (rsp_if.valid !== 1'b0 || get_resp() !== '0) begin
            errors++;
            $display("FAIL reset_out: valid=%b payload=%h need valid=0 payload=0", rsp_if.valid, get_resp());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b need 1", req_if.ready);
        end
    endtask

    task automatic test_fill();
        rsp_if.ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            send(1'b0, '1, MEM_ADDR_WIDTH'(a), $urandom, 4'(a));
        end
        drain();
    endtask

    task automatic test_masked_write_read();
        rsp_if.ready = 1'b1;
        send(1'b0, 4'b1111, 32'd5, 32'hDEADBEEF, 4'd0);
        send(1'b0, 4'b0001, 32'd5, 32'h000000AA, 4'd0);
        send(1'b1, 4'b0000, 32'd5, 32'h0, 4'd3);
        checks++;
        if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'hDEADBEAA || rsp_if.id !== 4'd3 || rsp_if.addr !== 32'd5 ||
            rsp_if.read_enable !== 1'b1 || rsp_if.write_enable !== 4'h0) begin
            errors++;
            $display("FAIL masked_read: valid=%b data=%h id=%0d addr=%h re=%b we=%b, need 1 deadbeaa 3 5 1 0",
                     rsp_if.valid, rsp_if.data, rsp_if.id, rsp_if.addr, rsp_if.read_enable, rsp_if.write_enable);
        end
        drain();
    endtask

    task automatic test_alias();
        send(1'b1, 4'b0000, 32'(5 + DEPTH), 32'h0, 4'd7);
        checks++;
        if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'hDEADBEAA || rsp_if.addr !== 32'(5 + DEPTH)) begin
            errors++;
            $display("FAIL alias_read: valid=%b data=%h addr=%h, need 1 deadbeaa %h", rsp_if.valid, rsp_if.data, rsp_if.addr, 32'(5 + DEPTH));
        end
        drain();
    endtask

    task automatic test_backpressure();
        int base;
        int rbase;
        int n;
        drain();
        rbase = resp_cnt;
        rsp_if.ready = 1'b0;
        send(1'b1, 4'h0, 32'($urandom_range(0, DEPTH - 1)), 32'h0, 4'd1);
        send(1'b1, 4'h0, 32'($urandom_range(0, DEPTH - 1)), 32'h0, 4'd2);
        base = accept_cnt;
        req_if.valid = 1'b1;
        req_if.read_enable = 1'b1;
        req_if.write_enable = 4'h0;
        req_if.addr = 32'($urandom_range(0, DEPTH - 1));
        req_if.id = 4'd3;
        repeat (4) tick();
        checks++;
        if (accept_cnt != base || req_if.ready !== 1'b0 || rsp_if.valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: extra accepts=%0d in_ready=%b out_valid=%b, need 0 0 1", accept_cnt - base, req_if.ready, rsp_if.valid);
        end
        rsp_if.ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 10);
        req_if.valid = 1'b0;
        drain();
        checks++;
        if (resp_cnt - rbase != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d responses need 3", resp_cnt - rbase);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int rbase;
        drain();
        rbase = resp_cnt;
        start = cycle_cnt;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 4'h0, 32'($urandom_range(0, 2 * DEPTH - 1)), 32'h0, 4'(i));
        end
        checks++;
        if (cycle_cnt - start != 16) begin
            errors++;
            $display("FAIL b2b_cycles: 16 accepts took %0d cycles need 16", cycle_cnt - start);
        end
        drain();
        checks++;
        if (resp_cnt - rbase != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses need 16", resp_cnt - rbase);
        end
    endtask

    task automatic test_read_write_same();
        rsp_if.ready = 1'b1;
        send(1'b0, 4'b1111, 32'd9, 32'h0, 4'd0);
        send(1'b1, 4'b1111, 32'd9, 32'h12345678, 4'd2);
        checks++;
        if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h0 || rsp_if.id !== 4'd2) begin
            errors++;
            $display("FAIL rmw_old: valid=%b data=%h id=%0d need 1 00000000 2", rsp_if.valid, rsp_if.data, rsp_if.id);
        end
        send(1'b1, 4'b0000, 32'd9, 32'h0, 4'd4);
        checks++;
        if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h12345678) begin
            errors++;
            $display("FAIL rmw_new: valid=%b data=%h need 1 12345678", rsp_if.valid, rsp_if.data);
        end
        drain();
    endtask

    task automatic test_write_ack();
        int rbase;
        drain();
        rbase = resp_cnt;
        send(1'b0, 4'b0110, 32'd20, $urandom, 4'd5);
        send(1'b0, 4'b0000, 32'd21, $urandom, 4'd6);
        send(1'b0, 4'b1001, 32'd22, $urandom, 4'd7);
        drain();
        repeat (3) tick();
        checks++;
        if (resp_cnt - rbase != (WACK ? 3 : 0)) begin
            errors++;
            $display("FAIL write_ack_count: got %0d responses need %0d", resp_cnt - rbase, WACK ? 3 : 0);
        end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 400; c++) begin
            if (req_if.valid !== 1'b1 && $urandom_range(0, 9) < 7) begin
                req_if.valid = 1'b1;
                req_if.read_enable = 1'($urandom_range(0, 1));
                req_if.write_enable = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                req_if.addr = 32'($urandom_range(0, 2 * DEPTH - 1));
                req_if.data = $urandom;
                req_if.id = 4'($urandom_range(0, 15));
            end
            rsp_if.ready = ($urandom_range(0, 9) < 6);
            tick();
            if (last_in_fire) req_if.valid = 1'b0;
        end
        n = 0;
        while (req_if.valid === 1'b1 && n < 20) begin
            rsp_if.ready = 1'b1;
            tick();
            if (last_in_fire) req_if.valid = 1'b0;
            n++;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        drain();
        rsp_if.ready = 1'b0;
        send(1'b1, 4'h0, 32'd5, 32'h0, 4'd8);
        send(1'b1, 4'h0, 32'd9, 32'h0, 4'd9);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_if.valid !== 1'b0 || get_resp() !== '0 || req_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b payload=%h in_ready=%b need 0 0 0", rsp_if.valid, get_resp(), req_if.ready);
        end
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release_ready: got %b need 1", req_if.ready);
        end
        rsp_if.ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        req_if.valid = 1'b0;
        req_if.read_enable = 1'b0;
        req_if.write_enable = '0;
        req_if.addr = '0;
        req_if.data = '0;
        req_if.id = '0;
        rsp_if.ready = 1'b0;
        stall_prev = 1'b0;
        #2;
        rst = 1'b0;
        test_reset();
        test_fill();
        test_masked_write_read();
        test_alias();
        test_backpressure();
        test_back_to_back();
        test_read_write_same();
        test_write_ack();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
